hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Pipeline sequencing controller for the decode stage of the LEGv8 five-stage pipeline.
- Tracks destination registers of in-flight instructions and stalls decode on RAW hazards. The pipeline has no forwarding.
- Handles taken-branch flushes and keeps saturating stall/flush statistics.
- Sits beside the decode stage. It drives the PC/IF-ID hold, the ID-EX bubble insert and the IF-ID flush.

Parameters:
- DEPTH, 3, tracked in-flight stages after decode (index 0 = EX ... DEPTH-1 = WB); legal 2..6.
- FLUSH_CYCLES, 2, cycles decode insertion is blocked after a taken branch; legal 1..4.
- CNT_W, 16, width of statistic counters.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1  in  5  instruction[9:5].
- id_rs2  in  5  second read register after Reg2Loc mux.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  5  destination register.
- id_reg_write  in  1  RegWrite control of the decode instruction.
- branch_taken  in  1  taken branch resolved in MEM (single-cycle pulse).
- stall  out  1  hold PC and IF-ID register.
- bubble  out  1  force ID-EX controls to zero this cycle.
- flush  out  1  clear IF-ID instruction.
- busy_mask  out  32  bit r set when register r has a pending write in entries 0..DEPTH-2.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flush events.

Behaviour:
- Tracker state: DEPTH entries {valid, rd}, shifted every cycle 0→1→…→DEPTH-1, then dropped. Entry 0 loads the decode instruction when it is inserted, else a bubble (valid=0).
- Insertion occurs when state=RUN, id_valid=1, hazard=0, branch_taken=0. Entry valid is set only if id_reg_write=1 and id_rd≠31; XZR is never tracked.
- Hazard window: entries 0..DEPTH-2 only. The WB entry is excluded because the register file writes before it reads within a cycle.
- hazard = id_valid and [(id_rs1≠31 and rs1 matches a valid window entry) or (id_uses_rs2 and id_rs2≠31 and rs2 matches a valid window entry)].
- busy_mask, hazard, stall and bubble are combinational from current tracker state and inputs.
- State machine RUN / STALL / FLUSH:
  - RUN: hazard → stall=1, bubble=1, next STALL. branch_taken → FLUSH.
  - STALL: stall=1 and bubble=1 while hazard persists. Leaves when hazard clears; that cycle inserts normally, stall=0, next RUN. branch_taken overrides → FLUSH.
  - FLUSH: entered on branch_taken from any state. In the branch_taken cycle, entry 0's next value is invalid and entries younger than the branch (EX) are invalidated before shifting. flush=1, bubble=1, stall=0 for FLUSH_CYCLES cycles counted by an internal down-counter. Return to RUN when the counter reaches 0.
- branch_taken during FLUSH restarts the counter at FLUSH_CYCLES and increments flush_count again.
- stall_count increments on every cycle with stall=1. flush_count increments on every branch_taken pulse. Both saturate at all-ones, with no wrap.
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - all tracker entries invalid, state RUN, flush counter 0, both statistic counters 0;
  - stall=0, bubble=0, flush=0, busy_mask=0.
- Simultaneous hazard and branch_taken: branch_taken wins (flush, no stall, no insertion).

Test Plan:
- ADD X1,X2,X3 then SUB X4,X1,X5 back-to-back → stall=1 for DEPTH-1=2 cycles, bubble on each; SUB inserted on the 3rd cycle; stall_count=2.
- Writer to X31 followed by reader of X31 → no stall; busy_mask stays 0.
- LDUR X7 then STUR with id_uses_rs2=1 and rs2=X7 → 2 stall cycles. Same sequence with id_uses_rs2=0 and rs1=X9 → 0 stalls.
- ADD X1 then branch_taken on the next cycle while a hazarding reader sits in decode → flush=1 for 2 cycles, stall=0, EX entry invalidated, busy_mask[1] cleared; flush_count=1.
- Second branch_taken in FLUSH cycle 1 → FLUSH extends to 2 cycles after the second pulse; flush_count=2.
- Assert reset mid-STALL → outputs go to 0 immediately without a clock edge. After release, the same reader inserts in 0 cycles because the tracker is empty. With CNT_W=4, 20 stall cycles → stall_count=15.

Source files
------------

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - LEGv8 decode-stage RAW hazard stall and taken-branch flush sequencer
module hazard_sequencer #(
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             branch_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

    state_t           state;
    logic [2:0]       flush_cnt;
    logic [DEPTH-1:0] ent_valid;
    logic [4:0]       ent_rd [DEPTH];
    logic             hazard;
    logic             in_flush;
    logic             insert;

    // WB entry is left out of the window: the register file writes before it reads
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (ent_valid[i]) begin
                busy_mask[ent_rd[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        hazard   = id_valid &&
                   (((id_rs1 != 5'd31) && busy_mask[id_rs1]) ||
                    (id_uses_rs2 && (id_rs2 != 5'd31) && busy_mask[id_rs2]));
        in_flush = (state == S_FLUSH);
        stall    = hazard && !branch_taken && !in_flush;
        bubble   = stall || branch_taken || in_flush;
        flush    = in_flush;
        insert   = id_valid && !hazard && !branch_taken && !in_flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i] <= 5'd0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_rd[i]    <= ent_rd[i-1];
            end
            // the EX-stage instruction is younger than the MEM branch and gets squashed
            if (branch_taken) begin
                ent_valid[1] <= 1'b0;
            end
            ent_valid[0] <= insert && id_reg_write && (id_rd != 5'd31);
            ent_rd[0]    <= id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            flush_cnt <= 3'd0;
        end else if (branch_taken) begin
            state     <= S_FLUSH;
            flush_cnt <= 3'(FLUSH_CYCLES);
        end else begin
            case (state)
                S_RUN:   if (hazard) state <= S_STALL;
                S_STALL: if (!hazard) state <= S_RUN;
                S_FLUSH: begin
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
            if (branch_taken && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule
